// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module : uart_pkg
// Brief  : Shared UART types. The entry record is used by both the receive
//          and transmit FIFOs so the storage array can be reused unchanged.
// Rev    : 1.0  initial release
// ============================================================================
package uart_pkg;

    // One buffered byte plus its frame-error flag, 9 bits total.
    typedef struct packed {
        logic       frame_err;
        logic [7:0] data;
    } uart_rx_entry_t;

    localparam int ENTRY_W = $bits(uart_rx_entry_t);

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module : uart_fifo_mem
// Brief  : DEPTH x WIDTH register array, one synchronous write port and one
//          asynchronous read port. The array is deliberately not reset.
// Ports  : clock_i  - system clock
//          we_i     - write enable
//          waddr_i  - write address
//          wdata_i  - write data
//          raddr_i  - read address
//          rdata_o  - read data (combinational from raddr_i)
// Rev    : 1.0  initial release
// ============================================================================
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = ENTRY_W,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clock_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clock_i) begin
        if (we_i) begin
            r_mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = r_mem[raddr_i];

endmodule : uart_fifo_mem
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module : uart_rx_fifo
// Brief  : Receive buffer behind the UART receiver. Captures each completed
//          byte with its frame-error flag, presents the oldest entry
//          first-word-fall-through, and reports fill level, sticky overrun
//          and a threshold interrupt.
// Ports  : clock_i, reset_i (async, active-high)
//          rx_data_i/rx_complete_i/rx_frame_err_i - push side from receiver
//          rd_i, flush_i, clear_overrun_i, irq_level_i - CPU controls
//          rd_data_o/rd_frame_err_o - head entry, 0 when empty
//          empty_o, full_o, count_o, overrun_o, irq_o - status
// Rev    : 1.0  initial release
// ============================================================================
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clock_i,
    input  logic                     reset_i,
    input  logic [7:0]               rx_data_i,
    input  logic                     rx_complete_i,
    input  logic                     rx_frame_err_i,
    input  logic                     rd_i,
    input  logic                     flush_i,
    input  logic                     clear_overrun_i,
    input  logic [$clog2(DEPTH):0]   irq_level_i,
    output logic [7:0]               rd_data_o,
    output logic                     rd_frame_err_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overrun_o,
    output logic                     irq_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] C_FULL_COUNT = CW'(DEPTH);
    localparam logic [CW-1:0] C_CNT_ONE    = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] C_PTR_ONE    = {{(AW-1){1'b0}}, 1'b1};

    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;
    logic           r_overrun;

    logic           w_empty;
    logic           w_full;
    logic           w_push;
    logic           w_pop;
    logic           w_mem_we;
    uart_rx_entry_t w_wr_entry;
    uart_rx_entry_t w_head;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == C_FULL_COUNT);

    // A push into a full FIFO is accepted only when a pop frees a slot in
    // the same cycle. A pop on an empty FIFO is ignored, so a push+pop into
    // an empty FIFO only pushes.
    assign w_push   = rx_complete_i && (!w_full || rd_i);
    assign w_pop    = rd_i && !w_empty;
    assign w_mem_we = w_push && !flush_i;

    assign w_wr_entry.frame_err = rx_frame_err_i;
    assign w_wr_entry.data      = rx_data_i;

    uart_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_mem (
        .clock_i (clock_i),
        .we_i    (w_mem_we),
        .waddr_i (r_wr_ptr),
        .wdata_i (w_wr_entry),
        .raddr_i (r_rd_ptr),
        .rdata_o (w_head)
    );

    // Pointer and count control. Flush overrides any same-cycle push/pop.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + C_CNT_ONE;
                2'b01:   r_count <= r_count - C_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overrun: set on a dropped byte, set wins over clear.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_overrun <= 1'b0;
        end else if (rx_complete_i && w_full && !rd_i) begin
            r_overrun <= 1'b1;
        end else if (clear_overrun_i) begin
            r_overrun <= 1'b0;
        end
    end

    // Head is read combinationally from the array; it only changes on the
    // clock edge that moves rd_ptr, so it is stable through an rd_i cycle.
    assign rd_data_o      = w_empty ? 8'h00 : w_head.data;
    assign rd_frame_err_o = w_empty ? 1'b0  : w_head.frame_err;
    assign empty_o        = w_empty;
    assign full_o         = w_full;
    assign count_o        = r_count;
    assign overrun_o      = r_overrun;

    // count never exceeds DEPTH, so a level above DEPTH can never assert.
    assign irq_o = (irq_level_i != '0) && (r_count >= irq_level_i);

endmodule : uart_rx_fifo
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module : tb_uart_rx_fifo
// Brief  : Self-checking bench for uart_rx_fifo (DEPTH=16).
// Rev    : 1.0  initial release
// ============================================================================
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;

    logic       clock_i;
    logic       reset_i;
    logic [7:0] rx_data_i;
    logic       rx_complete_i;
    logic       rx_frame_err_i;
    logic       rd_i;
    logic       flush_i;
    logic       clear_overrun_i;
    logic [4:0] irq_level_i;
    logic [7:0] rd_data_o;
    logic       rd_frame_err_o;
    logic       empty_o;
    logic       full_o;
    logic [4:0] count_o;
    logic       overrun_o;
    logic       irq_o;

    uart_rx_fifo #(.DEPTH(DEPTH)) dut (
        .clock_i         (clock_i),
        .reset_i         (reset_i),
        .rx_data_i       (rx_data_i),
        .rx_complete_i   (rx_complete_i),
        .rx_frame_err_i  (rx_frame_err_i),
        .rd_i            (rd_i),
        .flush_i         (flush_i),
        .clear_overrun_i (clear_overrun_i),
        .irq_level_i     (irq_level_i),
        .rd_data_o       (rd_data_o),
        .rd_frame_err_o  (rd_frame_err_o),
        .empty_o         (empty_o),
        .full_o          (full_o),
        .count_o         (count_o),
        .overrun_o       (overrun_o),
        .irq_o           (irq_o)
    );

    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    int n_cmp;
    int n_fail;

    typedef struct packed {
        logic       cmpl;
        logic [7:0] data;
        logic       err;
        logic       rd;
        logic       flush;
        logic       clr;
        logic [4:0] lvl;
        logic [4:0] e_count;
        logic       e_empty;
        logic       e_full;
        logic       e_ovr;
        logic       e_irq;
        logic [7:0] e_data;
        logic       e_err;
    } vec_t;

    localparam int NVEC = 24;
    vec_t tbl [NVEC];

    function automatic vec_t mk(logic c, logic [7:0] d, logic e, logic r, logic f,
                                logic [4:0] l, logic [4:0] ec, logic ee, logic eirq,
                                logic [7:0] ed, logic eerr);
        vec_t v;
        v.cmpl = c; v.data = d; v.err = e; v.rd = r; v.flush = f; v.clr = 1'b0;
        v.lvl = l; v.e_count = ec; v.e_empty = ee; v.e_full = 1'b0; v.e_ovr = 1'b0;
        v.e_irq = eirq; v.e_data = ed; v.e_err = eerr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply inputs for one clock, then sample just after the edge.
    task automatic step(input logic c, input logic [7:0] d, input logic e, input logic r,
                        input logic f, input logic clr, input logic [4:0] l);
        rx_complete_i   = c;
        rx_data_i       = d;
        rx_frame_err_i  = e;
        rd_i            = r;
        flush_i         = f;
        clear_overrun_i = clr;
        irq_level_i     = l;
        @(posedge clock_i);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".count"},   32'(count_o),        32'd0);
        check({tag, ".empty"},   32'(empty_o),        32'd1);
        check({tag, ".full"},    32'(full_o),         32'd0);
        check({tag, ".data"},    32'(rd_data_o),      32'd0);
        check({tag, ".ferr"},    32'(rd_frame_err_o), 32'd0);
        check({tag, ".overrun"}, 32'(overrun_o),      32'd0);
        check({tag, ".irq"},     32'(irq_o),          32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp  = 0;
        n_fail = 0;

        // Tests 1, 4, 5 and flush/empty corner cases as a vector table.
        //            c    data  e    rd   fl   lvl    cnt  emp  irq  data  err
        tbl[0]  = mk(1'b1, 8'h41, 1'b0, 1'b0, 1'b0, 5'd0, 5'd1, 1'b0, 1'b0, 8'h41, 1'b0);
        tbl[1]  = mk(1'b1, 8'h42, 1'b0, 1'b0, 1'b0, 5'd0, 5'd2, 1'b0, 1'b0, 8'h41, 1'b0);
        tbl[2]  = mk(1'b1, 8'h43, 1'b0, 1'b0, 1'b0, 5'd0, 5'd3, 1'b0, 1'b0, 8'h41, 1'b0);
        tbl[3]  = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 5'd0, 5'd2, 1'b0, 1'b0, 8'h42, 1'b0);
        tbl[4]  = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 5'd0, 5'd1, 1'b0, 1'b0, 8'h43, 1'b0);
        tbl[5]  = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 8'h00, 1'b0);
        tbl[6]  = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 8'h00, 1'b0);
        tbl[7]  = mk(1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 5'd0, 5'd1, 1'b0, 1'b0, 8'h55, 1'b1);
        tbl[8]  = mk(1'b1, 8'h66, 1'b0, 1'b0, 1'b0, 5'd0, 5'd2, 1'b0, 1'b0, 8'h55, 1'b1);
        tbl[9]  = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 5'd0, 5'd1, 1'b0, 1'b0, 8'h66, 1'b0);
        tbl[10] = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 8'h00, 1'b0);
        tbl[11] = mk(1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 5'd4, 5'd1, 1'b0, 1'b0, 8'h01, 1'b0);
        tbl[12] = mk(1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 5'd4, 5'd2, 1'b0, 1'b0, 8'h01, 1'b0);
        tbl[13] = mk(1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 5'd4, 5'd3, 1'b0, 1'b0, 8'h01, 1'b0);
        tbl[14] = mk(1'b1, 8'h04, 1'b0, 1'b0, 1'b0, 5'd4, 5'd4, 1'b0, 1'b1, 8'h01, 1'b0);
        tbl[15] = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 5'd4, 5'd3, 1'b0, 1'b0, 8'h02, 1'b0);
        tbl[16] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd0, 5'd3, 1'b0, 1'b0, 8'h02, 1'b0);
        tbl[17] = mk(1'b1, 8'h05, 1'b0, 1'b0, 1'b0, 5'd0, 5'd4, 1'b0, 1'b0, 8'h02, 1'b0);
        tbl[18] = mk(1'b1, 8'h06, 1'b0, 1'b1, 1'b0, 5'd0, 5'd4, 1'b0, 1'b0, 8'h03, 1'b0);
        tbl[19] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd17, 5'd4, 1'b0, 1'b0, 8'h03, 1'b0);
        tbl[20] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd3, 5'd4, 1'b0, 1'b1, 8'h03, 1'b0);
        tbl[21] = mk(1'b1, 8'h07, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 8'h00, 1'b0);
        tbl[22] = mk(1'b1, 8'h08, 1'b0, 1'b1, 1'b0, 5'd0, 5'd1, 1'b0, 1'b0, 8'h08, 1'b0);
        tbl[23] = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 8'h00, 1'b0);

        rx_complete_i = 1'b0; rx_data_i = 8'h00; rx_frame_err_i = 1'b0; rd_i = 1'b0;
        flush_i = 1'b0; clear_overrun_i = 1'b0; irq_level_i = 5'd0;
        reset_i = 1'b1;
        repeat (2) @(posedge clock_i);
        #1;
        check_reset_values("reset");
        @(negedge clock_i);
        reset_i = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            step(tbl[i].cmpl, tbl[i].data, tbl[i].err, tbl[i].rd, tbl[i].flush,
                 tbl[i].clr, tbl[i].lvl);
            check($sformatf("vec%0d.count", i), 32'(count_o),        32'(tbl[i].e_count));
            check($sformatf("vec%0d.empty", i), 32'(empty_o),        32'(tbl[i].e_empty));
            check($sformatf("vec%0d.full", i),  32'(full_o),         32'(tbl[i].e_full));
            check($sformatf("vec%0d.ovr", i),   32'(overrun_o),      32'(tbl[i].e_ovr));
            check($sformatf("vec%0d.irq", i),   32'(irq_o),          32'(tbl[i].e_irq));
            check($sformatf("vec%0d.data", i),  32'(rd_data_o),      32'(tbl[i].e_data));
            check($sformatf("vec%0d.ferr", i),  32'(rd_frame_err_o), 32'(tbl[i].e_err));
        end

        // Test 2: fill, overflow, drain, clear overrun.
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        end
        check("t2.full",     32'(full_o),    32'd1);
        check("t2.count",    32'(count_o),   32'd16);
        check("t2.ovr_pre",  32'(overrun_o), 32'd0);
        step(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        check("t2.ovr_set",  32'(overrun_o), 32'd1);
        check("t2.cnt_ovr",  32'(count_o),   32'd16);
        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("t2.drain%0d", i), 32'(rd_data_o), 32'(i));
            step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
        end
        check("t2.empty",    32'(empty_o),   32'd1);
        check("t2.ovr_hold", 32'(overrun_o), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0);
        check("t2.ovr_clr",  32'(overrun_o), 32'd0);

        // Test 3: full + push/pop same cycle; also set-wins-over-clear.
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        end
        step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0);
        check("t3.set_wins", 32'(overrun_o), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0);
        check("t3.ovr_clr",  32'(overrun_o), 32'd0);
        step(1'b1, 8'hAA, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
        check("t3.count",    32'(count_o),   32'd16);
        check("t3.full",     32'(full_o),    32'd1);
        check("t3.ovr",      32'(overrun_o), 32'd0);
        for (int i = 1; i < DEPTH; i++) begin
            check($sformatf("t3.drain%0d", i), 32'(rd_data_o), 32'(i));
            step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
        end
        check("t3.last",     32'(rd_data_o), 32'hAA);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
        check("t3.empty",    32'(empty_o),   32'd1);

        // Test 6: flush with same-cycle push.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        end
        check("t6.count5",   32'(count_o),   32'd5);
        step(1'b1, 8'h99, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0);
        check("t6.fl_count", 32'(count_o),   32'd0);
        check("t6.fl_empty", 32'(empty_o),   32'd1);
        check("t6.fl_data",  32'(rd_data_o), 32'd0);

        // Pointer wrap: 20 push/pop pairs.
        for (int k = 0; k < 20; k++) begin
            step(1'b1, 8'h80 + 8'(k), k[0], 1'b0, 1'b0, 1'b0, 5'd0);
            check($sformatf("t6.wrap%0d.data", k), 32'(rd_data_o),      32'(8'h80 + 8'(k)));
            check($sformatf("t6.wrap%0d.ferr", k), 32'(rd_frame_err_o), 32'(k[0]));
            step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
            check($sformatf("t6.wrap%0d.empty", k), 32'(empty_o), 32'd1);
        end

        // Async reset mid-stream with an overrun pending.
        for (int i = 0; i < DEPTH + 1; i++) begin
            step(1'b1, 8'h20 + 8'(i), 1'b1, 1'b0, 1'b0, 1'b0, 5'd2);
        end
        check("t6.pre_ovr",  32'(overrun_o), 32'd1);
        check("t6.pre_irq",  32'(irq_o),     32'd1);
        rx_complete_i = 1'b0;
        irq_level_i   = 5'd0;
        #2;
        reset_i = 1'b1;
        #1;
        check_reset_values("async_rst");
        @(negedge clock_i);
        reset_i = 1'b0;
        idle();
        check_reset_values("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_uart_rx_fifo
`default_nettype wire
